// File: rtl/simon_pkg.sv
// Shared Simon game constants: select encodings, default sizes, mode LEDs.
package simon_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int DEPTH_DEF  = 64;
  localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

  typedef enum logic [1:0] {
    SEL_PLAYBACK = 2'b00,
    SEL_REPEAT   = 2'b01,
    SEL_DONE     = 2'b10,
    SEL_RSVD     = 2'b11
  } sel_e;

  localparam logic [3:0] LED_INPUT  = 4'b0001;
  localparam logic [3:0] LED_PLAY   = 4'b0010;
  localparam logic [3:0] LED_REPEAT = 4'b0100;
  localparam logic [3:0] LED_DONE   = 4'b1000;

endpackage

// File: rtl/simon_pattern_mem.sv
// Pattern store: synchronous write, two asynchronous read ports.
module simon_pattern_mem #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/simon_datapath.sv
// Simon datapath: stores, replays and checks the pattern sequence.
// Define SIMON_HISCORE_EN to add the hiscore output register.
module simon_datapath
  import simon_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic [WIDTH-1:0] pattern,
  input  logic [1:0]       select,
  input  logic             clrcount,
  input  logic             w_en,
  output logic             is_legal,
  output logic             play_gt_count,
  output logic             repeat_eq_play,
  output logic             input_eq_pattern,
  output logic [WIDTH-1:0] pattern_leds
`ifdef SIMON_HISCORE_EN
  ,
  output logic [ADDR_W:0]  hiscore
`endif
);

  logic [ADDR_W:0]  count;
  logic [ADDR_W:0]  play_cnt;
  logic [ADDR_W:0]  rep_cnt;
  logic [WIDTH-1:0] rd_play;
  logic [WIDTH-1:0] rd_rep;
  logic             full;
  logic             match;
  logic             in_rep;
  logic             play_ok;
  logic             wr;

  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign match   = (pattern == rd_rep);
  assign in_rep  = (select == SEL_REPEAT);
  assign play_ok = (play_cnt < count);

  assign is_legal         = w_en & step & $onehot(pattern) & ~full;
  assign play_gt_count    = ~play_ok;
  assign input_eq_pattern = ~(in_rep & step & ~match);
  assign repeat_eq_play   = in_rep & step & match
                          & (rep_cnt == count - 1'b1);

  // clrcount also blocks the array write so a cleared game stays clean
  assign wr = is_legal & ~clrcount;

  simon_pattern_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we      (wr),
    .waddr   (count[ADDR_W-1:0]),
    .wdata   (pattern),
    .raddr_a (play_cnt[ADDR_W-1:0]),
    .rdata_a (rd_play),
    .raddr_b (rep_cnt[ADDR_W-1:0]),
    .rdata_b (rd_rep)
  );

  always_comb begin
    pattern_leds = '0;
    unique case (1'b1)
      (select == SEL_PLAYBACK),
      (select == SEL_DONE):   if (play_ok) pattern_leds = rd_play;
      (select == SEL_REPEAT): pattern_leds = pattern;
      (select == SEL_RSVD):   pattern_leds = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      play_cnt <= '0;
      rep_cnt  <= '0;
    end else if (clrcount) begin
      count    <= '0;
      play_cnt <= '0;
      rep_cnt  <= '0;
    end else if (is_legal) begin
      count    <= count + 1'b1;
      play_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      unique case (1'b1)
        (select == SEL_PLAYBACK): begin
          if (play_ok) play_cnt <= play_cnt + 1'b1;
        end
        (select == SEL_REPEAT): begin
          if (repeat_eq_play) begin
            rep_cnt  <= '0;
            play_cnt <= '0;
          end else if (step && match) begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        (select == SEL_DONE): begin
          if (count != '0) begin
            if (play_cnt >= count - 1'b1) play_cnt <= '0;
            else play_cnt <= play_cnt + 1'b1;
          end
        end
        (select == SEL_RSVD): begin
          play_cnt <= play_cnt;
        end
      endcase
    end
  end

`ifdef SIMON_HISCORE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiscore <= '0;
    end else if (wr && (count + 1'b1 > hiscore)) begin
      hiscore <= count + 1'b1;
    end
  end
`endif

endmodule

// File: doc/simon_datapath.md
Name: simon_datapath

Overview:
- Datapath counterpart to the Simon control FSM. It consumes the FSM's control outputs (select, clrcount, w_en) and produces the four status flags the FSM branches on (is_legal, play_gt_count, repeat_eq_play, input_eq_pattern).
- Stores the player-entered pattern sequence and replays it on the LEDs.
- Checks the player's repeat attempt and loops the sequence on the LEDs in the done state.

Parameters:
- WIDTH, 4, pattern width (one bit per switch/LED).
- DEPTH, 64, maximum stored sequence length.
- ADDR_W, 6, clog2(DEPTH). Count registers are ADDR_W+1 bits so they can hold DEPTH.

Ports:
- clk  input  1  game clock.
- rst_n  input  1  asynchronous active-low reset.
- step  input  1  one-cycle pulse from the debounced submit button.
- pattern  input  WIDTH  player switch value.
- select  input  2  mode from control: 00 playback, 01 repeat, 10 done, 11 reserved.
- clrcount  input  1  synchronous clear of all counters.
- w_en  input  1  input-mode write enable from control.
- is_legal  output  1  legal pattern submitted this cycle.
- play_gt_count  output  1  playback has passed the last stored entry.
- repeat_eq_play  output  1  final entry correctly repeated this cycle.
- input_eq_pattern  output  1  low for exactly the cycle of a wrong repeat.
- pattern_leds  output  WIDTH  LED drive.

Behaviour:
- Reset: clk plus rst_n, asynchronous active-low; all state resets on rst_n low.
  - count, play_cnt and rep_cnt reset to 0; memory contents are don't-care.
  - Outputs during reset: is_legal=0, play_gt_count=1 (count=0, play_cnt=0), repeat_eq_play=0, input_eq_pattern=1, pattern_leds=0.
- onehot = pattern has exactly one bit set. full = (count == DEPTH).
- Flags, all combinational, zero latency:
  - is_legal = w_en & step & onehot & !full.
  - play_gt_count = (play_cnt >= count).
  - match = (pattern == mem[rep_cnt]).
  - input_eq_pattern = !(select==01 & step & !match).
  - repeat_eq_play = select==01 & step & match & (rep_cnt == count-1).
- Write: when is_legal, mem[count] <= pattern, count <= count+1, play_cnt <= 0, rep_cnt <= 0. The write is visible to reads on the next cycle.
- Full: when full, a legal-looking step is ignored, is_legal stays 0, and the FSM remains in INPUT.
- Playback (select=00):
  - pattern_leds = mem[play_cnt] while play_cnt < count, else 0.
  - play_cnt increments every clock while play_cnt < count, then holds at count.
  - Result: entries 0..count-1 are each shown for one cycle, then the flag rises.
- Repeat (select=01):
  - pattern_leds = pattern (echo of the switches).
  - On step & match & !repeat_eq_play: rep_cnt += 1.
  - On repeat_eq_play: rep_cnt <= 0, play_cnt <= 0.
  - On mismatch: counters hold.
- Done (select=10):
  - pattern_leds = mem[play_cnt].
  - play_cnt increments each clock and wraps to 0 after count-1; if count==0, LEDs are 0.
- Reserved (select=11): pattern_leds = 0; counters hold.
- w_en is independent of select; the write path is evaluated regardless of select.
- clrcount: level-sensitive synchronous clear. It holds count, play_cnt and rep_cnt at 0 and has priority over writes and increments. Memory is not cleared.
- Simultaneous events:
  - clrcount beats is_legal.
  - A write beats the playback increment.
  - step outside input/repeat is ignored.
- Reset mid-operation: immediate asynchronous return to reset values; the stored sequence is lost logically because count=0.

Optional Feature:
- Macro: SIMON_HISCORE_EN.
- When defined:
  - Adds output hiscore [ADDR_W:0], a register holding the maximum count reached.
  - Updated when count+1 > hiscore on a write.
  - Cleared only by rst_n, never by clrcount.
- When undefined: the port and register are absent; all other behaviour is identical.

Decomposition:
- simon_pkg:
  - SEL_PLAYBACK=2'b00, SEL_REPEAT=2'b01, SEL_DONE=2'b10.
  - Default WIDTH/DEPTH constants.
  - Mode LED constants shared with control.
- Sub-module simon_pattern_mem: DEPTH x WIDTH register file with synchronous write and asynchronous read. No reset on the array.

Test Plan:
- Reset, then w_en=1, pattern=4'b0010, step pulse -> is_legal=1 that cycle; next cycle count=1 and mem[0]=0010. pattern=4'b0110 with step -> is_legal=0, count unchanged.
- Store 0001,0100,1000, select=00 -> pattern_leds shows 0001,0100,1000 on consecutive cycles, then 0000; play_gt_count=1 from the 4th cycle.
- select=01 with count=3, steps with 0001,0100,1000 -> input_eq_pattern stays 1; repeat_eq_play pulses only on the third step; rep_cnt=0 afterwards.
- select=01, first step with pattern=0010 against stored 0001 -> input_eq_pattern=0 for exactly that cycle; rep_cnt stays 0.
- Fill to DEPTH=64, then a further legal step -> is_legal=0, count=64. select=10 -> LEDs cycle through all 64 entries and wrap.
- Pulse clrcount during playback -> counters become 0 next cycle. With SIMON_HISCORE_EN, hiscore keeps its prior value of 3; asserting rst_n low mid-write -> count=0 immediately.
